// File: rtl/sabana_result_buffer.sv
// sabana_result_buffer: result FIFO for a ready/valid host reader with running sum,
// saturating result count and a batch-completion FSM.
module sabana_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int SUM_W = 40,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [CNT_W-1:0]        expect_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        rx_count,
    output logic [SUM_W-1:0]        sum,
    output logic                    busy,
    output logic                    batch_done,
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, exp_q, exp_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d, done_q, done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, rd_en, acc;

    always_comb begin
        full    = level_q == (AW+1)'(DEPTH);
        rd_en   = level_q != '0 && out_ready;
        // a read in the same cycle frees the slot, so a full FIFO still accepts
        acc     = in_valid && state_q != DONE && (!full || rd_en);
        wr_d    = wr_q + AW'(acc);
        rd_d    = rd_q + AW'(rd_en);
        level_d = level_q + (AW+1)'(acc) - (AW+1)'(rd_en);
        cnt_d   = (acc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        sum_d   = acc ? sum_q + SUM_W'(in_data) : sum_q;
        ovf_d   = ovf_q || (in_valid && !acc);
        exp_d   = (acc && state_q == IDLE) ? expect_n : exp_q;
        state_d = (acc && state_q == IDLE) ? COLLECT : state_q;
        done_d  = 1'b0;
        // rx_count is zero in IDLE, so expect_n==1 finishes on the very first accept
        if (acc && state_q != DONE && exp_d != '0 && cnt_d == exp_d) begin
            state_d = DONE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || clear) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clock) begin
        if (acc && !clear)
            mem_q[wr_q] <= in_data;
    end

    assign out_valid  = level_q != '0;
    assign out_data   = out_valid ? mem_q[rd_q] : '0;
    assign level      = level_q;
    assign rx_count   = cnt_q;
    assign sum        = sum_q;
    assign busy       = state_q == COLLECT;
    assign batch_done = done_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_sabana_result_buffer.sv
// tb_sabana_result_buffer: directed batch scenarios plus randomized traffic, scored
// against a queue-based reference model.
module tb_sabana_result_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] expect_n = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  level;
    logic [15:0] rx_count;
    logic [39:0] sum;
    logic        busy, batch_done, overflow;

    sabana_result_buffer #(.WIDTH(32), .DEPTH(8), .SUM_W(40), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .clear(clear), .expect_n(expect_n),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .level(level),
        .rx_count(rx_count), .sum(sum), .busy(busy), .batch_done(batch_done),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [31:0] sb[$];
    int          msize, mst;
    logic [15:0] mcount, mexp;
    logic [39:0] msum;
    bit          movf, mbd;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        msize = 0; mst = 0; mcount = '0; mexp = '0; msum = '0; movf = 0; mbd = 0;
    endtask

    task automatic check_status();
        chk("level", 64'(level), 64'(msize));
        chk("rx_count", 64'(rx_count), 64'(mcount));
        chk("sum", 64'(sum), 64'(msum));
        chk("overflow", 64'(overflow), 64'(movf));
        chk("busy", 64'(busy), 64'(mst == 1));
        chk("batch_done", 64'(batch_done), 64'(mbd));
        chk("out_valid", 64'(out_valid), 64'(msize > 0));
    endtask

    // one clock of traffic: drive, predict, advance, check status
    task automatic step(input bit v, input logic [31:0] d, input bit r);
        bit rd, acc;
        in_valid = v; in_data = d; out_ready = r;
        rd  = msize > 0 && r;
        acc = v && mst != 2 && (msize < 8 || rd);
        mbd = 0;
        if (acc) begin
            sb.push_back(d);
            if (mcount != 16'hFFFF) mcount++;
            msum = msum + {8'b0, d};
            if (mst == 0) begin mexp = expect_n; mst = 1; end
            if (mst == 1 && mexp != 0 && mcount == mexp) begin mst = 2; mbd = 1; end
        end
        if (v && !acc) movf = 1;
        msize = msize + int'(acc) - int'(rd);
        @(posedge clock); #1;
        check_status();
    endtask

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b0;
        @(posedge clock); #1;
        clear = 1'b0; in_valid = 1'b0;
        model_reset();
        check_status();
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pop: got %0h expected no data", out_data);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL pop_data: got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    initial begin
        model_reset();
        #2;
        check_status();
        chk("reset_out_data", 64'(out_data), 64'd0);
        #10 reset = 1'b0;
        @(posedge clock); #1;

        // three-result batch, then drain
        expect_n = 16'd3;
        step(1, 32'd5, 0);
        step(1, 32'd7, 0);
        step(1, 32'd9, 0);
        chk("t1_level", 64'(level), 64'd3);
        chk("t1_sum", 64'(sum), 64'd21);
        chk("t1_rx", 64'(rx_count), 64'd3);
        chk("t1_done", 64'(batch_done), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 32'd0, 1);
        chk("t1_done_pulse", 64'(batch_done), 64'd0);

        // DONE drops input; clear restores acceptance
        step(1, 32'd42, 0);
        chk("t5_ovf", 64'(overflow), 64'd1);
        chk("t5_level", 64'(level), 64'd0);
        do_clear();
        expect_n = 16'd0;
        step(1, 32'd11, 0);
        chk("t5_accept", 64'(rx_count), 64'd1);
        step(0, 32'd0, 1);

        // overfill, then push at full with a same-cycle read
        do_clear();
        for (int i = 0; i < 9; i++) step(1, 32'(100 + i), 0);
        chk("t2_level", 64'(level), 64'd8);
        chk("t2_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) step(1, 32'(200 + i), 1);
        chk("t3_level", 64'(level), 64'd8);
        chk("t3_rx", 64'(rx_count), 64'd12);
        for (int i = 0; i < 8; i++) step(0, 32'd0, 1);

        // sum wraps modulo 2^40
        do_clear();
        for (int i = 0; i < 300; i++) step(1, 32'hFFFF_FFFF, 1);
        chk("t4_sum", 64'(sum), (64'd300 * 64'hFFFF_FFFF) & 64'hFF_FFFF_FFFF);
        step(0, 32'd0, 1);

        // asynchronous reset mid-batch
        do_clear();
        expect_n = 16'd10;
        for (int i = 0; i < 4; i++) step(1, 32'(300 + i), 0);
        chk("t6_pre_level", 64'(level), 64'd4);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_status();
        chk("t6_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // randomized traffic with random batch sizes and occasional clears
        do_clear();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 79) == 0) do_clear();
            expect_n = 16'($urandom_range(0, 12));
            step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 4);
        end
        for (int i = 0; i < 10; i++) step(0, 32'd0, 1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
